// File: rtl/rv32i_encoder_loader_pkg.sv
// Shared RV32I definitions: ALU codes, operand types, opcodes, funct fields
// and the decoded-record type used between the loader and its field packer.
package rv32i_encoder_loader_pkg;

    localparam logic [5:0] ALU_LUI  = 6'd0;
    localparam logic [5:0] ALU_JAL  = 6'd1;
    localparam logic [5:0] ALU_JALR = 6'd2;
    localparam logic [5:0] ALU_BEQ  = 6'd3;
    localparam logic [5:0] ALU_BNE  = 6'd4;
    localparam logic [5:0] ALU_BLT  = 6'd5;
    localparam logic [5:0] ALU_BGE  = 6'd6;
    localparam logic [5:0] ALU_BLTU = 6'd7;
    localparam logic [5:0] ALU_BGEU = 6'd8;
    localparam logic [5:0] ALU_LB   = 6'd9;
    localparam logic [5:0] ALU_LH   = 6'd10;
    localparam logic [5:0] ALU_LW   = 6'd11;
    localparam logic [5:0] ALU_LBU  = 6'd12;
    localparam logic [5:0] ALU_LHU  = 6'd13;
    localparam logic [5:0] ALU_SB   = 6'd14;
    localparam logic [5:0] ALU_SH   = 6'd15;
    localparam logic [5:0] ALU_SW   = 6'd16;
    localparam logic [5:0] ALU_ADD  = 6'd17;
    localparam logic [5:0] ALU_SUB  = 6'd18;
    localparam logic [5:0] ALU_SLL  = 6'd19;
    localparam logic [5:0] ALU_SLT  = 6'd20;
    localparam logic [5:0] ALU_SLTU = 6'd21;
    localparam logic [5:0] ALU_XOR  = 6'd22;
    localparam logic [5:0] ALU_SRL  = 6'd23;
    localparam logic [5:0] ALU_SRA  = 6'd24;
    localparam logic [5:0] ALU_OR   = 6'd25;
    localparam logic [5:0] ALU_AND  = 6'd26;

    localparam logic [1:0] OP_TYPE_NONE = 2'd0;
    localparam logic [1:0] OP_TYPE_REG  = 2'd1;
    localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
    localparam logic [1:0] OP_TYPE_PC   = 2'd3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    typedef struct packed {
        logic [5:0]  alucode;
        logic [1:0]  op1_type;
        logic [1:0]  op2_type;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } instr_rec_t;

    function automatic logic is_arith(input logic [5:0] alu);
        return alu inside {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                           ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
    endfunction

    function automatic logic [2:0] arith_funct3(input logic [5:0] alu);
        case (alu)
            ALU_SLL:          return F3_SLL;
            ALU_SLT:          return F3_SLT;
            ALU_SLTU:         return F3_SLTU;
            ALU_XOR:          return F3_XOR;
            ALU_SRL, ALU_SRA: return F3_SR;
            ALU_OR:           return F3_OR;
            ALU_AND:          return F3_AND;
            default:          return F3_ADD;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_field_packer.sv
// Combinational record -> RV32I word encoder; flags keys and immediates that
// the decoder could never have produced.
module rv32i_field_packer
    import rv32i_encoder_loader_pkg::*;
(
    input  instr_rec_t  rec,
    output logic [31:0] word,
    output logic        illegal
);

    logic [31:0] imm;
    logic        s12_ok, b_ok, j_ok, u_ok, sh_ok;
    logic        key_ok, rng_ok;
    fmt_e        fmt;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [3:0]  types;

    assign imm    = rec.imm;
    assign types  = {rec.op1_type, rec.op2_type};
    assign s12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_ok   = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign j_ok   = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    assign u_ok   = ~(|imm[11:0]);
    assign sh_ok  = ~(|imm[31:5]);

    always_comb begin
        key_ok = 1'b0;
        rng_ok = 1'b0;
        fmt    = FMT_R;
        opc    = 7'd0;
        f3     = 3'd0;
        f7     = F7_BASE;
        case (rec.alucode)
            ALU_LUI: begin
                key_ok = (types == {OP_TYPE_NONE, OP_TYPE_IMM});
                rng_ok = u_ok; fmt = FMT_U; opc = OPC_LUI;
            end
            ALU_JAL: begin
                key_ok = (types == {OP_TYPE_NONE, OP_TYPE_PC});
                rng_ok = j_ok; fmt = FMT_J; opc = OPC_JAL;
            end
            ALU_JALR: begin
                key_ok = (types == {OP_TYPE_REG, OP_TYPE_PC});
                rng_ok = s12_ok; fmt = FMT_I; opc = OPC_JALR;
            end
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: begin
                key_ok = (types == {OP_TYPE_REG, OP_TYPE_REG});
                rng_ok = b_ok; fmt = FMT_B; opc = OPC_BRANCH;
                case (rec.alucode)
                    ALU_BNE:  f3 = F3_BNE;
                    ALU_BLT:  f3 = F3_BLT;
                    ALU_BGE:  f3 = F3_BGE;
                    ALU_BLTU: f3 = F3_BLTU;
                    ALU_BGEU: f3 = F3_BGEU;
                    default:  f3 = F3_BEQ;
                endcase
            end
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU: begin
                key_ok = 1'b1; rng_ok = s12_ok; fmt = FMT_I; opc = OPC_LOAD;
                case (rec.alucode)
                    ALU_LH:  f3 = F3_H;
                    ALU_LW:  f3 = F3_W;
                    ALU_LBU: f3 = F3_BU;
                    ALU_LHU: f3 = F3_HU;
                    default: f3 = F3_B;
                endcase
            end
            ALU_SB, ALU_SH, ALU_SW: begin
                key_ok = 1'b1; rng_ok = s12_ok; fmt = FMT_S; opc = OPC_STORE;
                case (rec.alucode)
                    ALU_SH:  f3 = F3_H;
                    ALU_SW:  f3 = F3_W;
                    default: f3 = F3_B;
                endcase
            end
            default: begin
                f3 = arith_funct3(rec.alucode);
                if (!is_arith(rec.alucode)) begin
                    key_ok = 1'b0;
                end else if (types == {OP_TYPE_REG, OP_TYPE_REG}) begin
                    key_ok = 1'b1; rng_ok = 1'b1; fmt = FMT_R; opc = OPC_OP;
                    f7 = (rec.alucode inside {ALU_SUB, ALU_SRA}) ? F7_ALT : F7_BASE;
                end else if (types == {OP_TYPE_REG, OP_TYPE_IMM}) begin
                    key_ok = (rec.alucode != ALU_SUB);
                    opc    = OPC_OPIMM;
                    if (rec.alucode inside {ALU_SLL, ALU_SRL, ALU_SRA}) begin
                        fmt = FMT_SH; rng_ok = sh_ok;
                        f7  = (rec.alucode == ALU_SRA) ? F7_ALT : F7_BASE;
                    end else begin
                        fmt = FMT_I; rng_ok = s12_ok;
                    end
                end else if (rec.alucode == ALU_ADD && types == {OP_TYPE_IMM, OP_TYPE_PC}) begin
                    key_ok = 1'b1; rng_ok = u_ok; fmt = FMT_U; opc = OPC_AUIPC;
                end
            end
        endcase
    end

    // Only fields the format actually carries are packed, so unused registers encode as 0.
    always_comb begin
        illegal = !(key_ok && rng_ok);
        word    = 32'd0;
        if (!illegal) begin
            case (fmt)
                FMT_R:  word = {f7, rec.rs2, rec.rs1, f3, rec.rd, opc};
                FMT_I:  word = {imm[11:0], rec.rs1, f3, rec.rd, opc};
                FMT_SH: word = {f7, imm[4:0], rec.rs1, f3, rec.rd, opc};
                FMT_S:  word = {imm[11:5], rec.rs2, rec.rs1, f3, imm[4:0], opc};
                FMT_B:  word = {imm[12], imm[10:5], rec.rs2, rec.rs1, f3, imm[4:1], imm[11], opc};
                FMT_U:  word = {imm[31:12], rec.rd, opc};
                FMT_J:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rec.rd, opc};
                default: word = 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_encoder_loader.sv
// Accepts decoded records, re-encodes them and streams the words into
// sequential imem addresses through a one-deep output register.
module rv32i_encoder_loader
    import rv32i_encoder_loader_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_alucode,
    input  logic [1:0]    in_op1_type,
    input  logic [1:0]    in_op2_type,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [4:0]    in_rd,
    input  logic [31:0]   in_imm,
    output logic          mem_we,
    input  logic          mem_ready,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          full,
    output logic          err_illegal,
    output logic [CW-1:0] word_count
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    instr_rec_t  rec;
    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        accept, complete;

    assign rec = '{alucode: in_alucode, op1_type: in_op1_type, op2_type: in_op2_type,
                   rs1: in_rs1, rs2: in_rs2, rd: in_rd, imm: in_imm};

    rv32i_field_packer u_packer (
        .rec     (rec),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready = !full && (!mem_we || mem_ready);
    assign accept   = in_valid && in_ready;
    assign complete = mem_we && mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we      <= 1'b0;
            mem_addr    <= BASE_ADDR;
            mem_wdata   <= 32'd0;
            full        <= 1'b0;
            err_illegal <= 1'b0;
            word_count  <= '0;
        end else begin
            err_illegal <= accept && enc_illegal;
            if (complete) begin
                mem_addr <= mem_addr + 32'd4;
                if (word_count != CNT_MAX)
                    word_count <= word_count + CW'(1);
                if (word_count == CNT_LAST)
                    full <= 1'b1;
            end
            // A new legal word overrides the completion so mem_we stays high back-to-back.
            if (accept && !enc_illegal) begin
                mem_we    <= 1'b1;
                mem_wdata <= enc_word;
            end else if (complete) begin
                mem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_encoder_loader.sv
// Directed bench for rv32i_encoder_loader with hand-encoded expected words.
module tb_rv32i_encoder_loader;
    import rv32i_encoder_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_alucode = '0;
    logic [1:0]  in_op1_type = '0, in_op2_type = '0;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [31:0] in_imm = '0;
    logic        mem_we, mem_ready = 1'b1;
    logic [31:0] mem_addr, mem_wdata;
    logic        full, err_illegal;
    logic [2:0]  word_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] alu; logic [1:0] t1, t2; logic [4:0] rs1, rs2, rd;
        logic [31:0] imm, exp;
    } vec_t;

    rv32i_encoder_loader #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_alucode(in_alucode), .in_op1_type(in_op1_type), .in_op2_type(in_op2_type),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .full(full), .err_illegal(err_illegal), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1; in_alucode = v.alu; in_op1_type = v.t1; in_op2_type = v.t2;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_imm = v.imm;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; mem_ready = 1'b1; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [5:0] alu, input logic [1:0] t1, input logic [1:0] t2,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [31:0] exp);
        vec_t v;
        v.alu = alu; v.t1 = t1; v.t2 = t2; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.imm = imm; v.exp = exp;
        return v;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", mem_wdata); end
        checks++; if ({full, err_illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {full, err_illegal}); end
        checks++; if (word_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", word_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_addi_latency();
        do_reset();
        drive(mk(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0));
        tick(); in_valid = 1'b0;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL addi_we: got %b exp 1", mem_we); end
        checks++; if (mem_wdata !== 32'h00500093) begin errors++; $display("FAIL addi_word: got %h exp 00500093", mem_wdata); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL addi_addr: got %h exp 0", mem_addr); end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL addi_done_we: got %b exp 0", mem_we); end
        checks++; if (word_count !== 3'd1) begin errors++; $display("FAIL addi_count: got %0d exp 1", word_count); end
        checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL addi_next_addr: got %h exp 4", mem_addr); end
    endtask

    task automatic test_encode();
        vec_t v[11];
        v[0]  = mk(ALU_SUB,  OP_TYPE_REG,  OP_TYPE_REG, 5'd1, 5'd2, 5'd3, 32'd0,          32'h402081B3);
        v[1]  = mk(ALU_ADD,  OP_TYPE_REG,  OP_TYPE_REG, 5'd1, 5'd2, 5'd3, 32'd0,          32'h002081B3);
        v[2]  = mk(ALU_LUI,  OP_TYPE_NONE, OP_TYPE_IMM, 5'd0, 5'd0, 5'd5, 32'h12345000,   32'h123452B7);
        v[3]  = mk(ALU_BEQ,  OP_TYPE_REG,  OP_TYPE_REG, 5'd1, 5'd2, 5'd0, 32'd8,          32'h00208463);
        v[4]  = mk(ALU_SRA,  OP_TYPE_REG,  OP_TYPE_IMM, 5'd1, 5'd0, 5'd1, 32'd3,          32'h4030D093);
        v[5]  = mk(ALU_JAL,  OP_TYPE_NONE, OP_TYPE_PC,  5'd0, 5'd0, 5'd1, 32'd8,          32'h008000EF);
        v[6]  = mk(ALU_JALR, OP_TYPE_REG,  OP_TYPE_PC,  5'd1, 5'd0, 5'd0, 32'd0,          32'h00008067);
        v[7]  = mk(ALU_LW,   OP_TYPE_REG,  OP_TYPE_IMM, 5'd1, 5'd0, 5'd2, 32'd4,          32'h0040A103);
        v[8]  = mk(ALU_SW,   OP_TYPE_REG,  OP_TYPE_IMM, 5'd1, 5'd2, 5'd0, 32'd8,          32'h0020A423);
        v[9]  = mk(ALU_ADD,  OP_TYPE_IMM,  OP_TYPE_PC,  5'd0, 5'd0, 5'd3, 32'h00001000,   32'h00001197);
        v[10] = mk(ALU_BNE,  OP_TYPE_REG,  OP_TYPE_REG, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC,   32'hFE209EE3);
        for (int i = 0; i < 11; i++) begin
            do_reset();
            drive(v[i]);
            tick(); in_valid = 1'b0;
            checks++;
            if (mem_we !== 1'b1 || mem_wdata !== v[i].exp || err_illegal !== 1'b0) begin
                errors++;
                $display("FAIL encode_%0d: got we=%b word=%h err=%b exp we=1 word=%h err=0",
                         i, mem_we, mem_wdata, err_illegal, v[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        vec_t v[7];
        v[0] = mk(ALU_BEQ, OP_TYPE_REG,  OP_TYPE_REG, 5'd1, 5'd2, 5'd0, 32'd4096,     32'h0);
        v[1] = mk(ALU_BEQ, OP_TYPE_REG,  OP_TYPE_REG, 5'd1, 5'd2, 5'd0, 32'd7,        32'h0);
        v[2] = mk(ALU_SUB, OP_TYPE_REG,  OP_TYPE_IMM, 5'd1, 5'd0, 5'd1, 32'd1,        32'h0);
        v[3] = mk(ALU_LUI, OP_TYPE_NONE, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'h12345001, 32'h0);
        v[4] = mk(ALU_SRA, OP_TYPE_REG,  OP_TYPE_IMM, 5'd1, 5'd0, 5'd1, 32'd32,       32'h0);
        v[5] = mk(ALU_ADD, OP_TYPE_REG,  OP_TYPE_IMM, 5'd1, 5'd0, 5'd1, 32'd2048,     32'h0);
        v[6] = mk(6'd63,   OP_TYPE_REG,  OP_TYPE_REG, 5'd1, 5'd2, 5'd3, 32'd0,        32'h0);
        do_reset();
        drive(mk(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0));
        tick(); in_valid = 1'b0; tick();
        for (int i = 0; i < 7; i++) begin
            drive(v[i]);
            tick(); in_valid = 1'b0;
            checks++;
            if (err_illegal !== 1'b1 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL illegal_%0d: got err=%b we=%b exp err=1 we=0", i, err_illegal, mem_we);
            end
            tick();
            checks++;
            if (err_illegal !== 1'b0 || word_count !== 3'd1 || mem_addr !== 32'h4) begin
                errors++;
                $display("FAIL illegal_after_%0d: got err=%b cnt=%0d addr=%h exp err=0 cnt=1 addr=4",
                         i, err_illegal, word_count, mem_addr);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_ready = 1'b0;
        drive(mk(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0));
        tick();
        drive(mk(ALU_SUB, OP_TYPE_REG, OP_TYPE_REG, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0));
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'h00500093 || mem_addr !== 32'h0) begin
                errors++;
                $display("FAIL stall_%0d: got rdy=%b we=%b word=%h addr=%h exp rdy=0 we=1 word=00500093 addr=0",
                         i, in_ready, mem_we, mem_wdata, mem_addr);
            end
            tick();
        end
        mem_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b exp 1", in_ready); end
        tick(); in_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h402081B3 || mem_addr !== 32'h4 || word_count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_second: got we=%b word=%h addr=%h cnt=%0d exp we=1 word=402081B3 addr=4 cnt=1",
                     mem_we, mem_wdata, mem_addr, word_count);
        end
        tick();
        checks++;
        if (mem_we !== 1'b0 || word_count !== 3'd2 || mem_addr !== 32'h8) begin
            errors++;
            $display("FAIL b2b_done: got we=%b cnt=%0d addr=%h exp we=0 cnt=2 addr=8", mem_we, word_count, mem_addr);
        end
    endtask

    task automatic test_full_and_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(mk(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'(i), 32'h0));
            tick();
        end
        in_valid = 1'b0;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early: got %b exp 0", full); end
        tick();
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || word_count !== 3'd4 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL full_set: got full=%b rdy=%b cnt=%0d addr=%h exp full=1 rdy=0 cnt=4 addr=10",
                     full, in_ready, word_count, mem_addr);
        end
        drive(mk(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd9, 32'h0));
        tick(); in_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || full !== 1'b1 || word_count !== 3'd4) begin
            errors++;
            $display("FAIL full_hold: got we=%b full=%b cnt=%0d exp we=0 full=1 cnt=4", mem_we, full, word_count);
        end
        do_reset();
        mem_ready = 1'b0;
        drive(mk(ALU_LUI, OP_TYPE_NONE, OP_TYPE_IMM, 5'd0, 5'd0, 5'd5, 32'h12345000, 32'h0));
        tick(); in_valid = 1'b0; tick();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_stall_pre: got we=%b exp 1", mem_we); end
        rst = 1'b1; tick();
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || full !== 1'b0 ||
            err_illegal !== 1'b0 || word_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_stall: got we=%b addr=%h wdata=%h full=%b err=%b cnt=%0d exp all zero",
                     mem_we, mem_addr, mem_wdata, full, err_illegal, word_count);
        end
        rst = 1'b0; mem_ready = 1'b1; tick();
        checks++;
        if (mem_we !== 1'b0 || word_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_dropped: got we=%b cnt=%0d exp we=0 cnt=0", mem_we, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_addi_latency();
        test_encode();
        test_illegal();
        test_back_to_back();
        test_full_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
